// File: rtl/mem_refill_arbiter_pkg.sv
// mem_refill_arbiter_pkg: shared widths, FSM states and word-index helper for the refill arbiter
package mem_refill_arbiter_pkg;
  localparam int ADR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int WORD_OFFSET_DEF = 2;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  // Critical-word-first index: start word plus beats consumed, wrapped to the line size
  function automatic int unsigned wrap_word(input int unsigned base, input int unsigned cnt, input int unsigned wo);
    return (base + cnt) % (32'd1 << wo);
  endfunction
endpackage

// File: rtl/mem_refill_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant; pointer moves past the last owner when upd is high
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       last,
  output logic       valid,
  output logic       idx
);
  logic ptr;
  // Priority pointer: after a finished burst the other requester wins the next tie
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= 1'b0;
    else if (upd) ptr <= ~last;
  // Tie goes to the pointer, otherwise the lone requester
  always_comb begin
    valid = |req;
    idx = &req ? ptr : req[1];
  end
endmodule

// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: shares the memory refill port between I-cache (0) and D-cache (1), one line burst per grant
module mem_refill_arbiter
  import mem_refill_arbiter_pkg::*;
#(
  parameter int ADR_WIDTH = ADR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int WORD_OFFSET = WORD_OFFSET_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_cc2mem0,
  input  logic [ADR_WIDTH-1:0]   adr_cc2mem0,
  output logic                   ack_mem2cc0,
  output logic [WORD_OFFSET-1:0] word_mem2cc0,
  input  logic                   req_cc2mem1,
  input  logic [ADR_WIDTH-1:0]   adr_cc2mem1,
  output logic                   ack_mem2cc1,
  output logic [WORD_OFFSET-1:0] word_mem2cc1,
  output logic [DATA_WIDTH-1:0]  dat_mem2cc,
  output logic                   req_arb2mem,
  output logic [ADR_WIDTH-1:0]   adr_arb2mem,
  input  logic                   ack_mem2arb,
  input  logic [DATA_WIDTH-1:0]  dat_mem2arb
);
  state_t state, state_n;
  logic owner, gnt_valid, gnt_idx, grant, last, owner_req, busy;
  logic [WORD_OFFSET-1:0] count, word;
  logic [ADR_WIDTH-1:0] adr_q;
  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   ({req_cc2mem1, req_cc2mem0}),
    .upd   (last),
    .last  (owner),
    .valid (gnt_valid),
    .idx   (gnt_idx)
  );
  // Next state: grant from IDLE, leave BUSY on the final beat, leave DRAIN once the owner lets go
  always_comb begin
    state_n = state;
    busy = state == BUSY;
    owner_req = owner ? req_cc2mem1 : req_cc2mem0;
    grant = state == IDLE && gnt_valid;
    last = busy && ack_mem2arb && &count;
    state_n = grant ? BUSY : last ? DRAIN : (state == DRAIN && !owner_req) ? IDLE : state;
  end
  // State, owner, latched address and beat counter; a reset drops any partial burst
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      count <= '0;
      adr_q <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        owner <= gnt_idx;
        adr_q <= gnt_idx ? adr_cc2mem1 : adr_cc2mem0;
        count <= '0;
      end else if (busy && ack_mem2arb) count <= count + 1'b1;
    end
  // Memory side is held for the full burst; acks reach only a still-requesting owner
  always_comb begin
    req_arb2mem = busy;
    adr_arb2mem = adr_q;
    dat_mem2cc = dat_mem2arb;
    ack_mem2cc0 = busy && ack_mem2arb && !owner && req_cc2mem0;
    ack_mem2cc1 = busy && ack_mem2arb && owner && req_cc2mem1;
    word = WORD_OFFSET'(wrap_word(32'(adr_q[WORD_OFFSET+1:2]), 32'(count), WORD_OFFSET));
    word_mem2cc0 = owner ? '0 : word;
    word_mem2cc1 = owner ? word : '0;
  end
endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb_mem_refill_arbiter: directed and random refills checked against a transaction-level arbitration model
module tb_mem_refill_arbiter;
  localparam int AW = 32, DW = 32, WO = 2, BL = 1 << WO;
  logic clk = 0, rst = 1, r0 = 0, r1 = 0, mack = 0;
  logic [AW-1:0] a0 = 0, a1 = 0;
  logic [DW-1:0] mdat = 0;
  logic k0, k1, rq;
  logic [WO-1:0] w0, w1;
  logic [DW-1:0] dat;
  logic [AW-1:0] adr;
  typedef struct {logic rq; logic [AW-1:0] adr; logic k0, k1; logic [WO-1:0] w0, w1; logic [DW-1:0] dat;} exp_t;
  exp_t exp_q[$];
  exp_t me;
  int log_q[$];
  int total = 0, bad = 0;
  int cur = -1, done = 0, ptr = 0;
  bit drain = 0;
  logic [AW-1:0] madr = 0;
  bit want0 = 0, want1 = 0;
  int ex1[4] = '{2, 3, 0, 1};
  int ex2[8] = '{3, 0, 1, 2, 16, 17, 18, 19};
  int ex6[4] = '{18, 19, 16, 17};

  mem_refill_arbiter dut (
    .clk(clk), .rst(rst),
    .req_cc2mem0(r0), .adr_cc2mem0(a0), .ack_mem2cc0(k0), .word_mem2cc0(w0),
    .req_cc2mem1(r1), .adr_cc2mem1(a1), .ack_mem2cc1(k1), .word_mem2cc1(w1),
    .dat_mem2cc(dat), .req_arb2mem(rq), .adr_arb2mem(adr),
    .ack_mem2arb(mack), .dat_mem2arb(mdat)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, ex);
    end
  endfunction

  function automatic void chk_log(string nm, int i, int ex);
    chk(nm, 64'(i < log_q.size() ? log_q[i] : -1), 64'(ex));
  endfunction

  // One bus cycle: drive inputs, queue what the spec says must appear, then advance the model
  task automatic step(input logic q0, input logic q1, input logic ack, input logic [DW-1:0] d);
    exp_t e;
    bit bsy;
    @(posedge clk); #1;
    r0 = q0; r1 = q1; mack = ack; mdat = d;
    bsy = cur >= 0 && !drain;
    e.rq = bsy;
    e.adr = madr;
    e.dat = d;
    e.k0 = bsy && ack && cur == 0 && q0;
    e.k1 = bsy && ack && cur == 1 && q1;
    e.w0 = WO'((int'(madr[WO+1:2]) + done) % BL);
    e.w1 = e.w0;
    exp_q.push_back(e);
    if (cur < 0) begin
      if (q0 || q1) begin
        cur = (q0 && q1) ? ptr : (q1 ? 1 : 0);
        madr = cur == 1 ? a1 : a0;
        done = 0;
      end
    end else if (!drain) begin
      if (ack) begin
        done++;
        if (done == BL) begin
          drain = 1;
          ptr = 1 - cur;
        end
      end
    end else if (!(cur == 1 ? q1 : q0)) begin
      cur = -1;
      drain = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    mack = 0; r0 = 0; r1 = 0; rst = 1;
    #1;
    chk("rst_req_arb2mem", 64'(rq), 0);
    chk("rst_adr_arb2mem", 64'(adr), 0);
    chk("rst_ack0", 64'(k0), 0);
    chk("rst_ack1", 64'(k1), 0);
    chk("rst_word0", 64'(w0), 0);
    chk("rst_word1", 64'(w1), 0);
    exp_q.delete();
    cur = -1; done = 0; drain = 0; ptr = 0; madr = 0;
    @(negedge clk); #2;
    rst = 0;
  endtask

  // Monitor: compare every cycle's outputs with the queued expectation and log forwarded beats
  always @(negedge clk) begin
    if (k0) log_q.push_back(int'(w0));
    if (k1) log_q.push_back(16 + int'(w1));
    if (!rst && exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk("req_arb2mem", 64'(rq), 64'(me.rq));
      chk("adr_arb2mem", 64'(adr), 64'(me.adr));
      chk("ack_mem2cc0", 64'(k0), 64'(me.k0));
      chk("ack_mem2cc1", 64'(k1), 64'(me.k1));
      if (me.k0) begin
        chk("word_mem2cc0", 64'(w0), 64'(me.w0));
        chk("dat_mem2cc0", 64'(dat), 64'(me.dat));
      end
      if (me.k1) begin
        chk("word_mem2cc1", 64'(w1), 64'(me.w1));
        chk("dat_mem2cc1", 64'(dat), 64'(me.dat));
      end
    end
  end

  initial begin
    do_reset();
    a0 = 32'hFF07BD08;
    log_q.delete();
    step(1, 0, 0, 0);
    repeat (4) step(1, 0, 1, 32'hFFFFFFFF);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("single_len", 64'(log_q.size()), 4);
    for (int i = 0; i < 4; i++) chk_log("single_word", i, ex1[i]);

    do_reset();
    a0 = 32'hA5552D0C;
    a1 = 32'hD500AD00;
    log_q.delete();
    step(1, 1, 0, 0);
    repeat (4) step(1, 1, 1, $urandom);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    repeat (4) step(0, 1, 1, $urandom);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("contend_len", 64'(log_q.size()), 8);
    for (int i = 0; i < 8; i++) chk_log("contend_word", i, ex2[i]);

    do_reset();
    log_q.delete();
    for (int rd = 0; rd < 6; rd++) begin
      step(1, 1, 0, 0);
      repeat (4) step(1, 1, 1, $urandom);
      step(rd % 2 == 1, rd % 2 == 0, 0, 0);
    end
    step(0, 0, 0, 0);
    chk("fair_len", 64'(log_q.size()), 24);
    for (int rd = 0; rd < 6; rd++)
      chk("fair_owner", 64'(rd * 4 < log_q.size() ? log_q[rd * 4] / 16 : -1), 64'(rd % 2));

    log_q.delete();
    step(0, 1, 0, 0);
    repeat (2) step(0, 1, 1, $urandom);
    repeat (2) step(0, 0, 1, $urandom);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("abort_len", 64'(log_q.size()), 2);
    chk_log("abort_word", 0, 16);
    chk_log("abort_word", 1, 17);

    log_q.delete();
    repeat (3) step(0, 0, 1, $urandom);
    step(0, 0, 0, 0);
    chk("idle_ack_len", 64'(log_q.size()), 0);

    a1 = 32'h12345678;
    step(0, 1, 0, 0);
    repeat (2) step(0, 1, 1, $urandom);
    do_reset();
    log_q.delete();
    step(0, 1, 0, 0);
    repeat (4) step(0, 1, 1, $urandom);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("post_rst_len", 64'(log_q.size()), 4);
    for (int i = 0; i < 4; i++) chk_log("post_rst_word", i, ex6[i]);

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step(want0, want1, $urandom_range(2) != 0, $urandom);
      if (want0) begin
        if (cur == 0 && (drain || $urandom_range(39) == 0)) want0 = 0;
      end else if (cur != 0 && $urandom_range(2) == 0) begin
        want0 = 1;
        a0 = $urandom;
      end
      if (want1) begin
        if (cur == 1 && (drain || $urandom_range(39) == 0)) want1 = 0;
      end else if (cur != 1 && $urandom_range(2) == 0) begin
        want1 = 1;
        a1 = $urandom;
      end
    end
    step(0, 0, 0, 0);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
